// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op codes, FSM states and unit select for the HI/LO sequencer

package muldiv_pkg;

  // Control-unit request encodings; anything else behaves as a NOP.
  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_MULT = 3'b001;
  localparam logic [2:0] OP_DIV  = 3'b010;
  localparam logic [2:0] OP_MTHI = 3'b011;
  localparam logic [2:0] OP_MTLO = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_ARM   = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

  typedef enum logic {
    SEL_MUL = 1'b0,
    SEL_DIV = 1'b1
  } sel_e;

  // Width of a counter that must reach the larger of the two timeouts.
  function automatic int cnt_width(input int arm_to, input int run_to);
    int m;
    m = (arm_to > run_to) ? arm_to : run_to;
    return $clog2(m + 2);
  endfunction

endpackage

// File: rtl/muldiv_hilo_ctrl.sv
// rtl/muldiv_hilo_ctrl.sv - MULT/DIV/MTHI/MTLO sequencer with architectural HI/LO registers

module muldiv_hilo_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int ARM_TIMEOUT = 2,
  parameter int RUN_TIMEOUT = 40
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             unit_reset,
  output logic [WIDTH-1:0] unit_a,
  output logic [WIDTH-1:0] unit_b,
  output logic             mul_start,
  input  logic             mul_fim,
  input  logic [WIDTH-1:0] mul_hi,
  input  logic [WIDTH-1:0] mul_lo,
  output logic             div_start,
  input  logic             div_fim,
  input  logic [WIDTH-1:0] div_hi,
  input  logic [WIDTH-1:0] div_lo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             dz
);

  localparam int CNT_W = cnt_width(ARM_TIMEOUT, RUN_TIMEOUT);
  localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(ARM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_TIMEOUT);

  state_e             state_q, state_d;
  sel_e               sel_q, sel_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               dz_q, dz_d;

  logic               fim_sel;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  // The units share one reset with us but are active-high.
  assign unit_reset = ~reset;

  // Mux the handshake and result of whichever unit this op was issued to.
  assign fim_sel = (sel_q == SEL_MUL) ? mul_fim : div_fim;
  assign res_hi  = (sel_q == SEL_MUL) ? mul_hi  : div_hi;
  assign res_lo  = (sel_q == SEL_MUL) ? mul_lo  : div_lo;

  // Start is decoded from the one-cycle START state, so pulses are exclusive and single-cycle.
  assign mul_start = (state_q == ST_START) && (sel_q == SEL_MUL);
  assign div_start = (state_q == ST_START) && (sel_q == SEL_DIV);

  assign unit_a = a_q;
  assign unit_b = b_q;
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;
  assign err    = err_q;
  assign dz     = dz_q;

  // Next-state, operand latch, timeout counter and HI/LO update.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = err_q;
    dz_d    = dz_q;

    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          case (op_code)
            OP_MULT: begin
              a_d     = rs_val;
              b_d     = rt_val;
              sel_d   = SEL_MUL;
              err_d   = 1'b0;
              dz_d    = 1'b0;
              state_d = ST_START;
            end
            OP_DIV: begin
              err_d = 1'b0;
              if (rt_val == '0) begin
                // Retire immediately without touching the divider or HI/LO.
                dz_d   = 1'b1;
                done_d = 1'b1;
              end else begin
                a_d     = rs_val;
                b_d     = rt_val;
                sel_d   = SEL_DIV;
                dz_d    = 1'b0;
                state_d = ST_START;
              end
            end
            OP_MTHI: begin
              hi_d   = rs_val;
              done_d = 1'b1;
              err_d  = 1'b0;
              dz_d   = 1'b0;
            end
            OP_MTLO: begin
              lo_d   = rs_val;
              done_d = 1'b1;
              err_d  = 1'b0;
              dz_d   = 1'b0;
            end
            default: ;
          endcase
        end
      end

      ST_START: begin
        cnt_d   = '0;
        state_d = ST_ARM;
      end

      // The unit must acknowledge start by dropping fim within the arm window.
      ST_ARM: begin
        if (!fim_sel) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end else if (cnt_q >= ARM_LAST) begin
          state_d = ST_ERROR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RUN: begin
        if (fim_sel) begin
          hi_d    = res_hi;
          lo_d    = res_lo;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q >= RUN_LAST) begin
          state_d = ST_ERROR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_ERROR: begin
        err_d   = 1'b1;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      sel_q   <= SEL_MUL;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      dz_q    <= dz_d;
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// tb/tb_muldiv_hilo_ctrl.sv - directed vector bench for the HI/LO sequencer

module tb_muldiv_hilo_ctrl;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         op_valid = 1'b0;
  logic [2:0]   op_code = OP_NOP;
  logic [W-1:0] rs_val = '0;
  logic [W-1:0] rt_val = '0;
  logic         unit_reset;
  logic [W-1:0] unit_a, unit_b;
  logic         mul_start, div_start;
  logic         mul_fim, div_fim;
  logic [W-1:0] mul_hi, mul_lo, div_hi, div_lo;
  logic [W-1:0] hi, lo;
  logic         busy, done, err, dz;

  logic         mul_stuck = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  muldiv_hilo_ctrl #(.WIDTH(W), .ARM_TIMEOUT(2), .RUN_TIMEOUT(40)) dut (
    .clock(clock), .reset(reset), .op_valid(op_valid), .op_code(op_code),
    .rs_val(rs_val), .rt_val(rt_val), .unit_reset(unit_reset),
    .unit_a(unit_a), .unit_b(unit_b),
    .mul_start(mul_start), .mul_fim(mul_fim), .mul_hi(mul_hi), .mul_lo(mul_lo),
    .div_start(div_start), .div_fim(div_fim), .div_hi(div_hi), .div_lo(div_lo),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .err(err), .dz(dz)
  );

  // 32-iteration signed multiplier model; operands are re-read when it finishes.
  logic m_fim;
  int   m_cnt;
  logic [63:0] m_prod;
  assign m_prod  = 64'($signed(unit_a)) * 64'($signed(unit_b));
  assign mul_fim = mul_stuck ? 1'b1 : m_fim;
  always_ff @(posedge clock) begin
    if (unit_reset) begin
      m_fim <= 1'b1; m_cnt <= 0; mul_hi <= '0; mul_lo <= '0;
    end else if (mul_start) begin
      m_fim <= 1'b0; m_cnt <= 32;
    end else if (!m_fim) begin
      if (m_cnt == 1) begin
        m_fim  <= 1'b1;
        mul_hi <= m_prod[63:32];
        mul_lo <= m_prod[31:0];
      end
      m_cnt <= m_cnt - 1;
    end
  end

  // 8-iteration signed divider model: hi = remainder, lo = quotient.
  logic d_fim;
  int   d_cnt;
  assign div_fim = d_fim;
  always_ff @(posedge clock) begin
    if (unit_reset) begin
      d_fim <= 1'b1; d_cnt <= 0; div_hi <= '0; div_lo <= '0;
    end else if (div_start) begin
      d_fim <= 1'b0; d_cnt <= 8;
    end else if (!d_fim) begin
      if (d_cnt == 1) begin
        d_fim <= 1'b1;
        if (unit_b != '0) begin
          div_lo <= W'($signed(unit_a) / $signed(unit_b));
          div_hi <= W'($signed(unit_a) % $signed(unit_b));
        end
      end
      d_cnt <= d_cnt - 1;
    end
  end

  typedef struct {
    logic [2:0]   code;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    int           exp_done_cyc;
    int           exp_done_cnt;
    int           exp_busy;
    int           exp_ms;
    int           exp_ds;
    logic         exp_dz;
    logic         exp_err;
  } vec_t;

  vec_t vecs [7];

  int r_done_cyc, r_done_cnt, r_busy, r_ms, r_ds, r_both, r_unstable;
  logic [W-1:0] hi_log [0:63];
  logic [W-1:0] lo_log [0:63];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one request, then observe max_cyc cycles; optionally hammer a second request while busy.
  task automatic run_op(input logic [2:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int max_cyc, input int inj_from, input logic [2:0] inj_code,
                        input logic [W-1:0] inj_rs);
    r_done_cyc = 0; r_done_cnt = 0; r_busy = 0; r_ms = 0; r_ds = 0; r_both = 0; r_unstable = 0;
    hi_log[0] = hi; lo_log[0] = lo;
    op_valid = 1'b1; op_code = code; rs_val = a; rt_val = b;
    tick();
    op_valid = 1'b0; op_code = OP_NOP; rs_val = '0; rt_val = '0;
    for (int c = 1; c <= max_cyc; c++) begin
      hi_log[c] = hi; lo_log[c] = lo;
      if (busy) r_busy++;
      if (mul_start) r_ms++;
      if (div_start) r_ds++;
      if (mul_start && div_start) r_both++;
      if (done) begin
        r_done_cnt++;
        if (r_done_cyc == 0) r_done_cyc = c;
      end
      if (busy && (unit_a !== a || unit_b !== b)) r_unstable++;
      if (inj_from > 0 && c >= inj_from && c < inj_from + 3) begin
        op_valid = 1'b1; op_code = inj_code; rs_val = inj_rs;
      end else begin
        op_valid = 1'b0; op_code = OP_NOP; rs_val = '0;
      end
      tick();
    end
  endtask

  initial begin
    logic [W-1:0] prev_hi, prev_lo;

    vecs[0] = '{OP_MTHI, 32'h12345678, 32'h0, 32'h12345678, 32'h9ABCDEF0, 1, 1, 0, 0, 0, 1'b0, 1'b0};
    vecs[1] = '{OP_MTLO, 32'h0BADF00D, 32'h0, 32'h12345678, 32'h0BADF00D, 1, 1, 0, 0, 0, 1'b0, 1'b0};
    vecs[2] = '{OP_MULT, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 35, 1, 34, 1, 0, 1'b0, 1'b0};
    vecs[3] = '{OP_DIV, 32'd100, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFEB, 1, 1, 0, 0, 0, 1'b1, 1'b0};
    vecs[4] = '{OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 11, 1, 10, 0, 1, 1'b0, 1'b0};
    vecs[5] = '{OP_MULT, 32'h80000000, 32'd2, 32'hFFFFFFFF, 32'h0, 35, 1, 34, 1, 0, 1'b0, 1'b0};
    vecs[6] = '{3'b111, 32'h55555555, 32'h1, 32'hFFFFFFFF, 32'h0, 0, 0, 0, 0, 0, 1'b0, 1'b0};

    // Reset state
    reset = 1'b0;
    tick(); tick();
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_dz", dz, 0);
    chk("rst_unit_a", unit_a, 0);
    chk("rst_unit_reset", unit_reset, 1);
    chk("rst_starts", {mul_start, div_start}, 0);
    reset = 1'b1;
    tick();
    chk("run_unit_reset", unit_reset, 0);

    // MTHI then MTLO on back-to-back edges
    op_valid = 1'b1; op_code = OP_MTHI; rs_val = 32'h12345678;
    tick();
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_done", done, 1);
    chk("mthi_busy", busy, 0);
    op_code = OP_MTLO; rs_val = 32'h9ABCDEF0;
    tick();
    chk("mtlo_lo", lo, 32'h9ABCDEF0);
    chk("mtlo_hi_kept", hi, 32'h12345678);
    chk("mtlo_done", done, 1);
    chk("mtlo_busy", busy, 0);
    op_valid = 1'b0; op_code = OP_NOP; rs_val = '0;
    tick();
    chk("mtx_done_clear", done, 0);

    // Table of single operations
    for (int i = 0; i < 7; i++) begin
      prev_hi = (i == 0) ? 32'h12345678 : vecs[i-1].exp_hi;
      prev_lo = (i == 0) ? 32'h9ABCDEF0 : vecs[i-1].exp_lo;
      run_op(vecs[i].code, vecs[i].rs, vecs[i].rt, 40, 0, OP_NOP, '0);
      chk($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
      chk($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
      chk($sformatf("v%0d_done_cyc", i), r_done_cyc, vecs[i].exp_done_cyc);
      chk($sformatf("v%0d_done_cnt", i), r_done_cnt, vecs[i].exp_done_cnt);
      chk($sformatf("v%0d_busy_cyc", i), r_busy, vecs[i].exp_busy);
      chk($sformatf("v%0d_mul_start", i), r_ms, vecs[i].exp_ms);
      chk($sformatf("v%0d_div_start", i), r_ds, vecs[i].exp_ds);
      chk($sformatf("v%0d_both_start", i), r_both, 0);
      chk($sformatf("v%0d_dz", i), dz, vecs[i].exp_dz);
      chk($sformatf("v%0d_err", i), err, vecs[i].exp_err);
      chk($sformatf("v%0d_oper_stable", i), r_unstable, 0);
      if (r_done_cyc > 1) begin
        chk($sformatf("v%0d_hi_before_done", i), hi_log[r_done_cyc-1], prev_hi);
        chk($sformatf("v%0d_lo_before_done", i), lo_log[r_done_cyc-1], prev_lo);
        chk($sformatf("v%0d_lo_at_done", i), lo_log[r_done_cyc], vecs[i].exp_lo);
      end
    end

    // Multiplier never acknowledges start: ARM window expires
    mul_stuck = 1'b1;
    run_op(OP_MULT, 32'd3, 32'd5, 10, 0, OP_NOP, '0);
    mul_stuck = 1'b0;
    chk("arm_to_err", err, 1);
    chk("arm_to_done_cyc", r_done_cyc, 5);
    chk("arm_to_done_cnt", r_done_cnt, 1);
    chk("arm_to_busy_cyc", r_busy, 4);
    chk("arm_to_hi", hi, 32'hFFFFFFFF);
    chk("arm_to_lo", lo, 32'h0);
    chk("arm_to_idle", busy, 0);
    run_op(OP_MTHI, 32'hCAFEF00D, 32'h0, 3, 0, OP_NOP, '0);
    chk("mthi_clears_err", err, 0);
    chk("mthi_after_err_hi", hi, 32'hCAFEF00D);

    // Reset in cycle 10 of a MULT
    op_valid = 1'b1; op_code = OP_MULT; rs_val = 32'd9; rt_val = 32'd9;
    tick();
    op_valid = 1'b0; op_code = OP_NOP; rs_val = '0; rt_val = '0;
    for (int c = 1; c < 10; c++) tick();
    chk("midrst_busy_before", busy, 1);
    reset = 1'b0;
    #1;
    chk("midrst_unit_reset", unit_reset, 1);
    tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    chk("midrst_unit_a", unit_a, 0);
    chk("midrst_done", done, 0);
    reset = 1'b1;
    begin
      int late_done;
      late_done = 0;
      for (int c = 0; c < 4; c++) begin
        tick();
        if (done || busy) late_done++;
      end
      chk("midrst_no_retire", late_done, 0);
    end
    run_op(OP_MULT, 32'd6, 32'd7, 40, 0, OP_NOP, '0);
    chk("post_rst_lo", lo, 42);
    chk("post_rst_hi", hi, 0);
    chk("post_rst_done_cyc", r_done_cyc, 35);

    // MTHI arriving while a MULT is busy is dropped
    run_op(OP_MULT, 32'h00010000, 32'h00030000, 40, 5, OP_MTHI, 32'hDEADBEEF);
    chk("busy_mthi_hi", hi, 32'd3);
    chk("busy_mthi_lo", lo, 32'd0);
    chk("busy_mthi_done_cnt", r_done_cnt, 1);
    chk("busy_mthi_done_cyc", r_done_cyc, 35);
    chk("busy_mthi_busy_cyc", r_busy, 34);
    chk("busy_mthi_stable", r_unstable, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
